yarvi_run_ctl: RTL and testbench
================================

// Module: yarvi_run_ctl
// PURPOSE
//  Debug run/halt/step sequencer for the 4-stage yarvi core. Drives the core's freeze input.
//  Counts retirements from ME (me_valid) and halts on request, after N-step completion, or on a PC breakpoint.
//  Sits beside the core top; debug requests come from the host/JTAG shim.
// PARAMETERS
//  STEP_W        16  width of step count and remaining-step counter
//  CNT_W         32  width of retired-instruction counter
//  DRAIN_CYCLES   3  cycles freeze is held in HALTING before halted asserts; legal range 1..15
//  RESET_HALTED   0  1: leave reset in HALTED (freeze=1, halted=1)
// PORTS
//  clock            in   1        rising-edge clock
//  reset            in   1        synchronous, active-high
//  dbg_halt_req     in   1        level; request halt
//  dbg_resume_req   in   1        level; leave HALTED, free-run
//  dbg_step_req     in   1        level; leave HALTED, run dbg_step_count retirements
//  dbg_step_count   in   STEP_W   steps per step request; sampled on acceptance; 0 is treated as 1
//  me_valid         in   1        one instruction retired this cycle
//  me_pc            in   VMSB+1   PC of the retiring instruction
//  freeze           out  1        registered; stalls the core
//  halted           out  1        registered; core is stopped and drained
//  halt_cause       out  2        0 none, 1 request, 2 step done, 3 breakpoint
//  step_done        out  1        one-cycle pulse on the cycle HALTED is entered from STEP
//  retired          out  CNT_W    count of me_valid cycles; wraps modulo 2^CNT_W
// BEHAVIOUR
//  States: RUN(freeze=0), STEP(freeze=0), HALTING(freeze=1), HALTED(freeze=1, halted=1).
//  Reset values
//   - State RUN, or HALTED if RESET_HALTED=1.
//   - freeze=halted=RESET_HALTED; halt_cause=0; step_done=0; retired=0; remaining=0; drain counter=0.
//  RUN
//   - dbg_halt_req -> HALTING, cause=1.
//   - Breakpoint hit -> HALTING, cause=3.
//   - Breakpoint beats halt_req on the same cycle.
//  STEP
//   - Each me_valid decrements remaining.
//   - me_valid with remaining==1 -> HALTING, cause=2, step flag set.
//   - Breakpoint hit beats step completion: cause=3, step flag cleared.
//   - dbg_halt_req -> HALTING, cause=1, step flag cleared.
//  HALTING
//   - Load drain counter with DRAIN_CYCLES on entry; decrement each cycle.
//   - At 0 -> HALTED. halted=1 and step_done=step flag are registered on that transition.
//   - All requests are ignored while in HALTING.
//  HALTED
//   - dbg_step_req beats dbg_resume_req.
//   - dbg_step_req: remaining<=max(dbg_step_count,1); -> STEP; cause<=0.
//   - dbg_resume_req: -> RUN; cause<=0.
//   - dbg_halt_req is ignored.
//   - halted deasserts and freeze deasserts on the same edge as the exit.
//  Latency
//   - Halt request sampled at edge N: freeze=1 after edge N, halted=1 after edge N+DRAIN_CYCLES+1.
//  Counters
//   - retired increments on every me_valid in any state, including HALTING.
//   - A retirement on a transition cycle is still counted.
//   - remaining is STEP_W unsigned and never underflows (exit occurs at 1).
//  Requests are level-sensitive. Holding halt_req while HALTED has no effect.
//  Reset asserted mid-operation returns to the reset state next edge; any in-progress step is discarded.
// CONFIGURATION
//  YARVI_RUN_CTL_BREAKPOINT_EN defined
//   - Adds ports bp_enable (in, 1) and bp_addr (in, VMSB+1).
//   - Hit = bp_enable & me_valid & (me_pc == bp_addr), evaluated in RUN and STEP only.
//   - The hitting instruction has retired before freeze takes effect.
//  Undefined
//   - The ports are absent; halt_cause is never 3.
// TESTING
//  1. Reset, RESET_HALTED=0 -> freeze=0, halted=0, halt_cause=0, retired=0.
//  2. 10 me_valid pulses, then halt_req at edge N -> retired=10; freeze=1 after N; halted=1 after N+4 (DRAIN=3); cause=1.
//  3. From HALTED: step_req with count=3 -> freeze=0 next cycle; after 3rd me_valid -> HALTING; step_done pulses once; cause=2.
//  4. step_req with count=0 -> halts after exactly 1 retirement; cause=2.
//  5. HALTED with step_req and resume_req both high -> STEP entered, not RUN.
//  6. BREAKPOINT_EN, bp_addr=0x80, me_valid with me_pc=0x80 while halt_req high -> cause=3; retired includes that instruction.

Source files
------------

// File: rtl/yarvi_run_ctl.sv
// Debug run/halt/step sequencer for the 4-stage yarvi core; drives the core freeze input.
// Optional PC breakpoint compare is built when YARVI_RUN_CTL_BREAKPOINT_EN is defined.
module yarvi_run_ctl #(
  parameter int STEP_W       = 16,
  parameter int CNT_W        = 32,
  parameter int VMSB         = 31,
  parameter int DRAIN_CYCLES = 3,
  parameter int RESET_HALTED = 0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              dbg_halt_req_i,
  input  logic              dbg_resume_req_i,
  input  logic              dbg_step_req_i,
  input  logic [STEP_W-1:0] dbg_step_count_i,
  input  logic              me_valid_i,
  input  logic [VMSB:0]     me_pc_i,
`ifdef YARVI_RUN_CTL_BREAKPOINT_EN
  input  logic              bp_enable_i,
  input  logic [VMSB:0]     bp_addr_i,
`endif
  output logic              freeze_o,
  output logic              halted_o,
  output logic [1:0]        halt_cause_o,
  output logic              step_done_o,
  output logic [CNT_W-1:0]  retired_o
);

  typedef enum logic [1:0] {S_RUN, S_STEP, S_HALTING, S_HALTED} state_e;

  localparam logic [1:0] C_NONE = 2'd0;
  localparam logic [1:0] C_REQ  = 2'd1;
  localparam logic [1:0] C_STEP = 2'd2;
  localparam logic [1:0] C_BP   = 2'd3;

  localparam state_e            RST_STATE = (RESET_HALTED != 0) ? S_HALTED : S_RUN;
  localparam logic              RST_FRZ   = (RESET_HALTED != 0);
  localparam logic [3:0]        DRAIN_LD  = 4'(DRAIN_CYCLES);
  localparam logic [STEP_W-1:0] ONE       = STEP_W'(1);

  state_e              state_q, state_d;
  logic [3:0]          drain_q, drain_d;
  logic [STEP_W-1:0]   remaining_q, remaining_d;
  logic [1:0]          cause_q, cause_d;
  logic                flag_q, flag_d;
  logic                freeze_q, freeze_d;
  logic                halted_q, halted_d;
  logic                step_done_q, step_done_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                bp_hit;

`ifdef YARVI_RUN_CTL_BREAKPOINT_EN
  assign bp_hit = bp_enable_i & me_valid_i & (me_pc_i == bp_addr_i);
`else
  logic unused_pc;
  assign unused_pc = ^me_pc_i;
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    remaining_d = remaining_q;
    cause_d     = cause_q;
    flag_d      = flag_q;
    freeze_d    = freeze_q;
    halted_d    = halted_q;
    step_done_d = 1'b0;
    retired_d   = retired_q + {{(CNT_W-1){1'b0}}, me_valid_i};
    case (state_q)
      S_RUN: begin
        if (bp_hit || dbg_halt_req_i) begin
          state_d  = S_HALTING;
          drain_d  = DRAIN_LD;
          freeze_d = 1'b1;
          flag_d   = 1'b0;
          cause_d  = bp_hit ? C_BP : C_REQ;
        end
      end
      S_STEP: begin
        // Breakpoint, then explicit halt, then step completion.
        if (bp_hit || dbg_halt_req_i) begin
          state_d  = S_HALTING;
          drain_d  = DRAIN_LD;
          freeze_d = 1'b1;
          flag_d   = 1'b0;
          cause_d  = bp_hit ? C_BP : C_REQ;
        end else if (me_valid_i) begin
          remaining_d = remaining_q - ONE;
          if (remaining_q == ONE) begin
            state_d  = S_HALTING;
            drain_d  = DRAIN_LD;
            freeze_d = 1'b1;
            flag_d   = 1'b1;
            cause_d  = C_STEP;
          end
        end
      end
      S_HALTING: begin
        if (drain_q == 4'd0) begin
          state_d     = S_HALTED;
          halted_d    = 1'b1;
          step_done_d = flag_q;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      S_HALTED: begin
        if (dbg_step_req_i) begin
          state_d     = S_STEP;
          remaining_d = (dbg_step_count_i == '0) ? ONE : dbg_step_count_i;
          cause_d     = C_NONE;
          freeze_d    = 1'b0;
          halted_d    = 1'b0;
        end else if (dbg_resume_req_i) begin
          state_d  = S_RUN;
          cause_d  = C_NONE;
          freeze_d = 1'b0;
          halted_d = 1'b0;
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= RST_STATE;
      drain_q     <= 4'd0;
      remaining_q <= '0;
      cause_q     <= C_NONE;
      flag_q      <= 1'b0;
      freeze_q    <= RST_FRZ;
      halted_q    <= RST_FRZ;
      step_done_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      remaining_q <= remaining_d;
      cause_q     <= cause_d;
      flag_q      <= flag_d;
      freeze_q    <= freeze_d;
      halted_q    <= halted_d;
      step_done_q <= step_done_d;
      retired_q   <= retired_d;
    end
  end

  assign freeze_o     = freeze_q;
  assign halted_o     = halted_q;
  assign halt_cause_o = cause_q;
  assign step_done_o  = step_done_q;
  assign retired_o    = retired_q;

endmodule

// File: tb/tb_yarvi_run_ctl.sv
// Self-checking bench for yarvi_run_ctl: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the run/halt/step rules.
module tb_yarvi_run_ctl;
  localparam int STEP_W = 16;
  localparam int CNT_W  = 32;
  localparam int VMSB   = 31;
  localparam int DRAIN  = 3;

  logic              clk = 1'b0;
  logic              rst, halt_req, resume_req, step_req, me_valid;
  logic [STEP_W-1:0] step_cnt;
  logic [VMSB:0]     me_pc;
  logic              freeze, halted, step_done;
  logic [1:0]        cause;
  logic [CNT_W-1:0]  retired;
`ifdef YARVI_RUN_CTL_BREAKPOINT_EN
  logic              bp_en;
  logic [VMSB:0]     bp_addr;
`endif

  always #5 clk = ~clk;

  yarvi_run_ctl #(.STEP_W(STEP_W), .CNT_W(CNT_W), .VMSB(VMSB),
                  .DRAIN_CYCLES(DRAIN), .RESET_HALTED(0)) dut (
    .clock_i(clk), .reset_i(rst),
    .dbg_halt_req_i(halt_req), .dbg_resume_req_i(resume_req),
    .dbg_step_req_i(step_req), .dbg_step_count_i(step_cnt),
    .me_valid_i(me_valid), .me_pc_i(me_pc),
`ifdef YARVI_RUN_CTL_BREAKPOINT_EN
    .bp_enable_i(bp_en), .bp_addr_i(bp_addr),
`endif
    .freeze_o(freeze), .halted_o(halted), .halt_cause_o(cause),
    .step_done_o(step_done), .retired_o(retired)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: mode names the phase, m_wait counts edges left until halted.
  localparam int M_RUN = 0, M_STEP = 1, M_DRAIN = 2, M_HALTED = 3;
  int               m_mode, m_wait, m_left;
  logic [1:0]       m_cause;
  logic             m_flag, m_done;
  logic [CNT_W-1:0] m_retired;

  function automatic logic bp_hit_now();
`ifdef YARVI_RUN_CTL_BREAKPOINT_EN
    return bp_en && me_valid && (me_pc == bp_addr);
`else
    return 1'b0;
`endif
  endfunction

  task automatic begin_halt(input logic [1:0] c, input logic f);
    m_mode  = M_DRAIN;
    m_wait  = DRAIN + 1;
    m_cause = c;
    m_flag  = f;
  endtask

  task automatic model_step();
    logic hit;
    hit = bp_hit_now();
    if (rst) begin
      m_mode = M_RUN; m_wait = 0; m_left = 0; m_cause = 0;
      m_flag = 0; m_done = 0; m_retired = 0;
      return;
    end
    m_done = 0;
    if (me_valid) m_retired = m_retired + 1;
    case (m_mode)
      M_RUN: begin
        if (hit) begin_halt(2'd3, 1'b0);
        else if (halt_req) begin_halt(2'd1, 1'b0);
      end
      M_STEP: begin
        if (hit) begin_halt(2'd3, 1'b0);
        else if (halt_req) begin_halt(2'd1, 1'b0);
        else if (me_valid) begin
          if (m_left == 1) begin_halt(2'd2, 1'b1);
          m_left = m_left - 1;
        end
      end
      M_DRAIN: begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
          m_mode = M_HALTED;
          m_done = m_flag;
        end
      end
      default: begin
        if (step_req) begin
          m_mode  = M_STEP;
          m_left  = (step_cnt == 0) ? 1 : int'(step_cnt);
          m_cause = 0;
        end else if (resume_req) begin
          m_mode  = M_RUN;
          m_cause = 0;
        end
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("freeze",    freeze,    (m_mode == M_DRAIN || m_mode == M_HALTED));
    chk("halted",    halted,    (m_mode == M_HALTED));
    chk("cause",     cause,     m_cause);
    chk("step_done", step_done, m_done);
    chk("retired",   retired,   m_retired);
  endtask

  task automatic idle();
    rst = 0; halt_req = 0; resume_req = 0; step_req = 0;
    me_valid = 0; step_cnt = 0; me_pc = 32'h100;
  endtask

  int pulses;

  initial begin
    idle();
`ifdef YARVI_RUN_CTL_BREAKPOINT_EN
    bp_en = 0; bp_addr = 32'h80;
`endif
    // Reset state
    rst = 1; cycle(); cycle(); rst = 0;
    chk("rst_freeze", freeze, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cause", cause, 0);
    chk("rst_retired", retired, 0);

    // Ten retirements then halt request: freeze next edge, halted DRAIN+1 edges later
    me_valid = 1;
    repeat (10) cycle();
    me_valid = 0;
    chk("ret10", retired, 32'd10);
    halt_req = 1; cycle(); halt_req = 0;
    chk("halt_freeze", freeze, 1);
    chk("halt_not_yet", halted, 0);
    repeat (DRAIN) cycle();
    chk("halt_still_draining", halted, 0);
    cycle();
    chk("halt_latency", halted, 1);
    chk("halt_cause_req", cause, 2'd1);

    // Step by 3
    step_req = 1; step_cnt = 3; cycle(); step_req = 0;
    chk("step_unfreeze", freeze, 0);
    me_valid = 1; repeat (3) cycle(); me_valid = 0;
    chk("step3_freeze", freeze, 1);
    pulses = 0;
    repeat (DRAIN + 3) begin cycle(); if (step_done) pulses++; end
    chk("step3_pulses", pulses, 1);
    chk("step3_cause", cause, 2'd2);
    chk("step3_halted", halted, 1);

    // Step count 0 behaves as 1
    step_req = 1; step_cnt = 0; cycle(); step_req = 0;
    me_valid = 1; cycle(); me_valid = 0;
    chk("step0_freeze", freeze, 1);
    repeat (DRAIN + 1) cycle();
    chk("step0_cause", cause, 2'd2);

    // Step beats resume
    step_req = 1; resume_req = 1; step_cnt = 1; cycle(); step_req = 0; resume_req = 0;
    me_valid = 1; cycle(); me_valid = 0;
    chk("step_beats_resume", freeze, 1);
    repeat (DRAIN + 1) cycle();
    chk("step_beats_resume_cause", cause, 2'd2);

`ifdef YARVI_RUN_CTL_BREAKPOINT_EN
    // Breakpoint beats halt request; hitting instruction is counted
    resume_req = 1; cycle(); resume_req = 0;
    bp_en = 1; halt_req = 1; me_valid = 1; me_pc = 32'h80;
    cycle();
    idle();
    repeat (DRAIN + 1) cycle();
    chk("bp_cause", cause, 2'd3);
    chk("bp_retired", retired, m_retired);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      halt_req   = ($urandom_range(0, 11) == 0);
      resume_req = ($urandom_range(0, 7) == 0);
      step_req   = ($urandom_range(0, 7) == 0);
      step_cnt   = STEP_W'($urandom_range(0, 4));
      me_valid   = $urandom_range(0, 1) == 1;
      me_pc      = 32'h80 + 32'($urandom_range(0, 2) * 4);
`ifdef YARVI_RUN_CTL_BREAKPOINT_EN
      bp_en      = ($urandom_range(0, 3) == 0);
`endif
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
